seg7_disp_sched: RTL and testbench

- Shared display scheduler for the six HEX digits: NREQ requesters (counters, status logic) write 4-bit hex values into per-digit slot registers through a round-robin arbitrated req/ack port.
- A scan sequencer time-shares one seg7x decoder across all slots, refreshing one slot's latched LED pattern per scan step.
- Sits between the value-producing logic and the board HEX outputs, replacing one decoder per digit.

---
 rtl/seg7_disp_pkg.sv | 50 +++++
 rtl/seg7_disp_sched_rr_arbiter.sv | 46 ++++
 rtl/seg7x.sv | 33 +++
 rtl/seg7_disp_sched.sv | 179 +++++++++++++++++
 tb/tb_seg7_disp_sched.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_disp_pkg.sv
// Shared types, constants and the round-robin pick function for the HEX display scheduler.
// Pure declarations; no state.
// Optional blink field is present when SEG7_DISP_BLINK_EN is defined.
package seg7_disp_pkg;

  // Active-low segments: all ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Widest requester vector the pick function handles.
  localparam int RR_MAX = 8;

  // One display slot as stored by the scheduler.
  typedef struct packed {
`ifdef SEG7_DISP_BLINK_EN
    logic       blink;
`endif
    logic       blank;
    logic [3:0] val;
  } slot_t;

`ifdef SEG7_DISP_BLINK_EN
  localparam slot_t SLOT_RST = '{blink: 1'b0, blank: 1'b1, val: 4'h0};
`else
  localparam slot_t SLOT_RST = '{blank: 1'b1, val: 4'h0};
`endif

  // Result of a round-robin search.
  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of eligible at or above ptr, wrapping modulo n.
  function automatic rr_pick_t nxt_rr(input logic [2:0] ptr,
                                      input logic [RR_MAX-1:0] eligible,
                                      input int n);
    rr_pick_t r;
    int       cand;
    r = '{vld: 1'b0, idx: 3'd0};
    for (int k = 0; k < RR_MAX; k++) begin
      cand = (int'(ptr) + k) % n;
      if (k < n && !r.vld && eligible[cand[2:0]]) begin
        r.vld = 1'b1;
        r.idx = cand[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_disp_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among eligible requesters, search starts at a registered pointer.
// Grant is combinational; the pointer advances past the winner at the next clk edge.
// Caller masks requesters that are still being acknowledged; no other backpressure.
module rr_arbiter
  import seg7_disp_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] eligible,
  output logic [NREQ-1:0] grant,
  output logic            vld
);

  logic [2:0]        ptr;
  logic [RR_MAX-1:0] elig_ext;
  rr_pick_t          pick;

  // Widen the request vector and search from the pointer.
  always_comb begin
    elig_ext             = '0;
    elig_ext[NREQ-1:0]   = eligible;
    pick                 = nxt_rr(ptr, elig_ext, NREQ);
  end

  assign vld = pick.vld;

  // Decode the winner index to a one-hot grant.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = pick.vld && (pick.idx == 3'(i));
    end
  end

  // Pointer moves one past the winner; holds when nobody wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= 3'd0;
    end else if (pick.vld) begin
      ptr <= 3'((int'(pick.idx) + 1) % NREQ);
    end
  end

endmodule

// File: rtl/seg7x.sv
// Hex digit to active-low seven-segment pattern (bit 0 = segment a, bit 6 = segment g).
// Combinational, zero latency.
// No flow control.
module seg7x (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Standard hex glyph table, including lowercase b and d.
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_disp_sched.sv
// Shared HEX display scheduler: arbitrated slot writes, one time-shared seg7x refreshing slots in turn.
// Ack one cycle after a request is eligible; a written value reaches leds within 1 + NSLOT*SCAN_DIV cycles.
// Requesters hold req until ack (one write per cycle); blink support under SEG7_DISP_BLINK_EN.
module seg7_disp_sched
  import seg7_disp_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NSLOT     = 6,
  parameter int SCAN_DIV  = 4,
`ifdef SEG7_DISP_BLINK_EN
  parameter int BLINK_DIV = 16,
`endif
  localparam int SW       = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*SW-1:0] wr_slot,
  input  logic [NREQ*4-1:0]  wr_val,
  input  logic [NREQ-1:0]    wr_blank,
`ifdef SEG7_DISP_BLINK_EN
  input  logic [NREQ-1:0]    wr_blink,
`endif
  output logic [NREQ-1:0]    ack,
  output logic [NSLOT*7-1:0] leds,
  output logic [SW-1:0]      scan_slot,
  output logic               err
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // ------------------------------------------------------------------
  // Write port arbitration
  // ------------------------------------------------------------------
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic            win_vld;
  logic [SW-1:0]   win_slot;
  logic            win_in_range;
  slot_t           win_dat;

  // A requester in its ack cycle is masked so it cannot be granted twice for one write.
  assign eligible = req & ~ack;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .grant    (grant),
    .vld      (win_vld)
  );

  // Steer the winning requester's fields onto a single write bus.
  always_comb begin
    win_slot = '0;
    win_dat  = SLOT_RST;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_slot      = wr_slot[i*SW +: SW];
        win_dat.val   = wr_val[i*4 +: 4];
        win_dat.blank = wr_blank[i];
`ifdef SEG7_DISP_BLINK_EN
        win_dat.blink = wr_blink[i];
`endif
      end
    end
    win_in_range = int'(win_slot) < NSLOT;
  end

  // Ack pulses for the granted requester; a write aimed past the last slot latches err.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack <= '0;
      err <= 1'b0;
    end else begin
      ack <= grant;
      if (win_vld && !win_in_range) begin
        err <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Slot storage
  // ------------------------------------------------------------------
  slot_t slots [NSLOT];

  // Out-of-range writes match no slot and leave storage untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NSLOT; k++) begin
        slots[k] <= SLOT_RST;
      end
    end else if (win_vld && win_in_range) begin
      for (int k = 0; k < NSLOT; k++) begin
        if (win_slot == SW'(k)) begin
          slots[k] <= win_dat;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Scan sequencer and shared decoder
  // ------------------------------------------------------------------
  logic [DW-1:0] div;
  logic          step;
  slot_t         cur;
  logic [6:0]    dec_seg;
  logic [6:0]    pattern;
  logic          dark;

  assign step = (div == DW'(SCAN_DIV - 1));

  // Pick the slot under refresh; reads pre-write contents so a same-cycle write shows next visit.
  always_comb begin
    cur = SLOT_RST;
    for (int k = 0; k < NSLOT; k++) begin
      if (scan_slot == SW'(k)) begin
        cur = slots[k];
      end
    end
  end

  seg7x u_dec (
    .hex (cur.val),
    .seg (dec_seg)
  );

`ifdef SEG7_DISP_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] bcnt;
  logic          phase;

  // Blink phase flips after every BLINK_DIV completed scan steps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (step) begin
      if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt  <= bcnt + BW'(1);
      end
    end
  end

  assign dark = cur.blank || (cur.blink && phase);
`else
  assign dark = cur.blank;
`endif

  assign pattern = dark ? SEG_BLANK : dec_seg;

  // Divider paces scan steps; on terminal count latch one slot's pattern and move on, wrapping without idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div       <= '0;
      scan_slot <= '0;
      leds      <= '1;
    end else if (step) begin
      div <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        if (scan_slot == SW'(k)) begin
          leds[k*7 +: 7] <= pattern;
        end
      end
      scan_slot <= (scan_slot == SW'(NSLOT - 1)) ? '0 : scan_slot + SW'(1);
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Self-checking bench for seg7_disp_sched: directed scenarios followed by randomized traffic.
// A time-indexed reference model predicts ack, err, scan_slot and every leds digit each cycle.
// Requesters obey the hold-until-ack handshake, dropping req in their ack cycle.
module tb_seg7_disp_sched;

  localparam int NREQ     = 4;
  localparam int NSLOT    = 6;
  localparam int SCAN_DIV = 4;
  localparam int SW       = 3;
  localparam int FRAME    = NSLOT * SCAN_DIV;
`ifdef SEG7_DISP_BLINK_EN
  localparam int BLINK_DIV = 16;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*SW-1:0] wr_slot;
  logic [NREQ*4-1:0]  wr_val;
  logic [NREQ-1:0]    wr_blank;
`ifdef SEG7_DISP_BLINK_EN
  logic [NREQ-1:0]    wr_blink;
`endif
  logic [NREQ-1:0]    ack;
  logic [NSLOT*7-1:0] leds;
  logic [SW-1:0]      scan_slot;
  logic               err;

  always #5 clk = ~clk;

  seg7_disp_sched #(
    .NREQ      (NREQ),
    .NSLOT     (NSLOT),
    .SCAN_DIV  (SCAN_DIV)
`ifdef SEG7_DISP_BLINK_EN
    , .BLINK_DIV (BLINK_DIV)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr_slot   (wr_slot),
    .wr_val    (wr_val),
    .wr_blank  (wr_blank),
`ifdef SEG7_DISP_BLINK_EN
    .wr_blink  (wr_blink),
`endif
    .ack       (ack),
    .leds      (leds),
    .scan_slot (scan_slot),
    .err       (err)
  );

  // Reference glyphs, active low, bit 0 = segment a.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state.
  int              m_val   [NSLOT];
  bit              m_blank [NSLOT];
  bit              m_blink [NSLOT];
  logic [6:0]      m_leds  [NSLOT];
  logic [NREQ-1:0] m_ack;
  int              m_ptr;
  bit              m_err;
  int              t;          // clock edges since reset released

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance the model by one clock edge using the inputs presented to that edge.
  task automatic model_edge();
    int w, s, ws;
    bit ph;
    if (!reset) begin
      for (int k = 0; k < NSLOT; k++) begin
        m_val[k] = 0; m_blank[k] = 1; m_blink[k] = 0; m_leds[k] = 7'h7F;
      end
      m_ack = '0; m_ptr = 0; m_err = 0; t = 0;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (w < 0 && req[i] && !m_ack[i]) w = i;
      end
      // Refresh reads the slot contents from before this edge's write.
      if (t % SCAN_DIV == SCAN_DIV - 1) begin
        s  = (t / SCAN_DIV) % NSLOT;
        ph = 0;
`ifdef SEG7_DISP_BLINK_EN
        ph = (((t / SCAN_DIV) / BLINK_DIV) % 2) == 1;
`endif
        m_leds[s] = (m_blank[s] || (m_blink[s] && ph)) ? 7'h7F : seg_tab[m_val[s]];
      end
      m_ack = '0;
      if (w >= 0) begin
        m_ack[w] = 1'b1;
        m_ptr    = (w + 1) % NREQ;
        ws       = int'(wr_slot[w*SW +: SW]);
        if (ws < NSLOT) begin
          m_val[ws]   = int'(wr_val[w*4 +: 4]);
          m_blank[ws] = wr_blank[w];
`ifdef SEG7_DISP_BLINK_EN
          m_blink[ws] = wr_blink[w];
`endif
        end else begin
          m_err = 1;
        end
      end
      t++;
    end
  endtask

  // One clock: update model at the edge, compare just after it, then retire acked requests.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack", 32'(ack), 32'(m_ack));
    chk("err", 32'(err), 32'(m_err));
    chk("scan_slot", 32'(scan_slot), 32'((t / SCAN_DIV) % NSLOT));
    for (int s = 0; s < NSLOT; s++) begin
      chk($sformatf("leds%0d", s), 32'(leds[s*7 +: 7]), 32'(m_leds[s]));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) req[i] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input int slot, input int val, input bit blank);
    wr_slot[i*SW +: SW] = SW'(slot);
    wr_val[i*4 +: 4]    = 4'(val);
    wr_blank[i]         = blank;
    req[i]              = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req = '0; wr_slot = '0; wr_val = '0; wr_blank = '0;
`ifdef SEG7_DISP_BLINK_EN
    wr_blink = '0;
`endif

    // Reset state, then idle scan stepping through a full frame and the wrap to slot 0.
    repeat (3) tick();
    n_chk++;
    assert (leds === {NSLOT{7'h7F}}) n_pass++;
    else $error("FAIL reset_leds observed=%0h", leds);
    reset = 1'b1;
    repeat (FRAME + 6) tick();

    // Single requester: ack one cycle later, digit appears within one frame plus one.
    set_req(1, 2, 4'hA, 1'b0);
    tick();
    chk("single_ack", 32'(ack), 32'h2);
    repeat (FRAME + 1) tick();
    chk("single_leds2", 32'(leds[2*7 +: 7]), 32'h08);
    chk("single_leds0", 32'(leds[0 +: 7]), 32'h7F);

    // All four requesting from ptr=0: grants in order 0..3, twice.
    reset = 1'b0; tick(); reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, i, i + 8, 1'b0);
      for (int k = 0; k < NREQ; k++) begin
        tick();
        chk($sformatf("rr_order_r%0d", r), 32'(ack), 32'(1 << k));
      end
      tick();
    end

    // Out-of-range slot: acked, err sticks, no leds change.
    repeat (FRAME) tick();
    set_req(3, 7, 4'h1, 1'b0);
    tick();
    chk("oor_ack", 32'(ack), 32'h8);
    chk("oor_err", 32'(err), 32'h1);
    repeat (FRAME + 2) tick();
    chk("oor_err_sticky", 32'(err), 32'h1);

    // Write landing on the refresh edge of slot 0: old pattern this visit, new one next visit.
    set_req(0, 0, 4'h1, 1'b0);
    repeat (FRAME + 2) tick();
    for (int n = 0; n < FRAME && (t % FRAME) != SCAN_DIV - 1; n++) tick();
    set_req(0, 0, 4'h5, 1'b0);
    tick();
    chk("same_cycle_ack", 32'(ack), 32'h1);
    chk("same_cycle_old", 32'(leds[0 +: 7]), 32'h79);
    repeat (FRAME) tick();
    chk("same_cycle_new", 32'(leds[0 +: 7]), 32'h12);

    // Reset mid-scan clears leds and err on the next cycle.
    repeat (5) tick();
    reset = 1'b0;
    tick();
    chk("midrst_err", 32'(err), 32'h0);
    n_chk++;
    assert (leds === {NSLOT{7'h7F}}) n_pass++;
    else $error("FAIL midrst_leds observed=%0h", leds);
    reset = 1'b1;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3) == 0);
`ifdef SEG7_DISP_BLINK_EN
          wr_blink[i] = $urandom_range(0, 1) == 1;
`endif
        end
      end
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
